score_display_driver: RTL and testbench



---
 rtl/score_display_pkg.sv | 41 ++++
 rtl/score_display_driver_bcd_to_seg7.sv | 31 +++
 rtl/score_display_driver.sv | 196 +++++++++++++++++++
 tb/tb_score_display_driver.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/score_display_pkg.sv
// Shared types and seven-segment constants for the score display.
// Segment order is {g,f,e,d,c,b,a}, active-high.
package score_display_pkg;

    typedef enum logic [1:0] {
        LIVE      = 2'd0,
        FLASH_ON  = 2'd1,
        FLASH_OFF = 2'd2
    } disp_state_t;

    typedef logic [1:0] digit_idx_t;

    localparam digit_idx_t IDX_ONES     = 2'd0;
    localparam digit_idx_t IDX_TENS     = 2'd1;
    localparam digit_idx_t IDX_HUNDREDS = 2'd2;

    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1101111;
    localparam logic [6:0] SEG_DASH  = 7'b1000000;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    function automatic logic [2:0] idx_onehot(digit_idx_t idx);
        logic [2:0] oh;
        oh = 3'b001;
        case (idx)
            IDX_TENS:     oh = 3'b010;
            IDX_HUNDREDS: oh = 3'b100;
            default:      oh = 3'b001;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/score_display_driver_bcd_to_seg7.sv
// Combinational BCD to seven-segment decoder with blanking.
// Non-decimal codes show a dash so bad digits stay visible.
module bcd_to_seg7
    import score_display_pkg::*;
(
    input  logic [3:0] bcd,
    input  logic       blank,
    output logic [6:0] seg
);

    // Decode one digit, forcing all segments off when blanked
    always_comb begin
        seg = SEG_BLANK;
        if (!blank) begin
            case (bcd)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                4'd9:    seg = SEG_9;
                default: seg = SEG_DASH;
            endcase
        end
    end

endmodule

// File: rtl/score_display_driver.sv
// Multiplexed 3-digit score display with leading-zero blanking
// and a frozen-score flash sequence after each game ends.
module score_display_driver
    import score_display_pkg::*;
#(
    parameter int SCAN_DIV    = 1000,
    parameter int BLINK_DIV   = 6000000,
    parameter int FLASH_COUNT = 3
) (
    input  logic       clk,
    input  logic       nRst,
    input  logic [3:0] bcd_ones,
    input  logic [3:0] bcd_tens,
    input  logic [3:0] bcd_hundreds,
    input  logic       isGameComplete,
    output logic [6:0] seg,
    output logic [2:0] digit_en,
    output logic       flashing
);

    localparam int SCAN_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int NUM_W   = (FLASH_COUNT > 1) ? $clog2(FLASH_COUNT) : 1;

    localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
    localparam logic [NUM_W-1:0]   NUM_LAST   = NUM_W'(FLASH_COUNT - 1);

    disp_state_t        state;
    disp_state_t        state_d;
    logic [SCAN_W-1:0]  scan_cnt;
    digit_idx_t         scan_idx;
    logic [BLINK_W-1:0] blink_cnt;
    logic [BLINK_W-1:0] blink_cnt_d;
    logic [NUM_W-1:0]   blink_num;
    logic [NUM_W-1:0]   blink_num_d;
    logic [3:0]         sh_ones;
    logic [3:0]         sh_tens;
    logic [3:0]         sh_hund;
    logic               ge_q;
    logic               go_evt;
    logic               blink_done;
    logic               use_shadow;
    logic [3:0]         src_ones;
    logic [3:0]         src_tens;
    logic [3:0]         src_hund;
    logic [3:0]         cur_digit;
    logic               cur_blank;
    logic [6:0]         dec_seg;

    assign go_evt     = isGameComplete & ~ge_q;
    assign blink_done = (blink_cnt == BLINK_LAST);

    // Register the game-complete level for rising-edge detection
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            ge_q <= 1'b0;
        end else begin
            ge_q <= isGameComplete;
        end
    end

    // Free-running digit scan, independent of the display state
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            scan_cnt <= '0;
            scan_idx <= IDX_ONES;
        end else if (scan_cnt == SCAN_LAST) begin
            scan_cnt <= '0;
            scan_idx <= (scan_idx == IDX_HUNDREDS) ? IDX_ONES
                                                   : scan_idx + 2'd1;
        end else begin
            scan_cnt <= scan_cnt + SCAN_W'(1);
        end
    end

    // Track the previous cycle's score while live; hold it otherwise
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            sh_ones <= '0;
            sh_tens <= '0;
            sh_hund <= '0;
        end else if (state == LIVE && !go_evt) begin
            sh_ones <= bcd_ones;
            sh_tens <= bcd_tens;
            sh_hund <= bcd_hundreds;
        end
    end

    // State, blink counter and blink number registers
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state     <= LIVE;
            blink_cnt <= '0;
            blink_num <= '0;
        end else begin
            state     <= state_d;
            blink_cnt <= blink_cnt_d;
            blink_num <= blink_num_d;
        end
    end

    // Flash sequencing; a fresh rising edge always restarts it
    always_comb begin
        state_d     = state;
        blink_cnt_d = blink_cnt;
        blink_num_d = blink_num;
        if (go_evt) begin
            state_d     = FLASH_ON;
            blink_cnt_d = '0;
            blink_num_d = '0;
        end else begin
            case (state)
                FLASH_ON: begin
                    if (blink_done) begin
                        state_d     = FLASH_OFF;
                        blink_cnt_d = '0;
                    end else begin
                        blink_cnt_d = blink_cnt + BLINK_W'(1);
                    end
                end
                FLASH_OFF: begin
                    if (blink_done) begin
                        blink_cnt_d = '0;
                        if (blink_num == NUM_LAST) begin
                            state_d     = LIVE;
                            blink_num_d = '0;
                        end else begin
                            state_d     = FLASH_ON;
                            blink_num_d = blink_num + NUM_W'(1);
                        end
                    end else begin
                        blink_cnt_d = blink_cnt + BLINK_W'(1);
                    end
                end
                default: begin
                    state_d     = LIVE;
                    blink_cnt_d = '0;
                    blink_num_d = '0;
                end
            endcase
        end
    end

    // Display mode follows the state being entered, so the digit
    // registers and flashing change on the same edge
    assign use_shadow = (state_d != LIVE);
    assign src_ones   = use_shadow ? sh_ones : bcd_ones;
    assign src_tens   = use_shadow ? sh_tens : bcd_tens;
    assign src_hund   = use_shadow ? sh_hund : bcd_hundreds;

    // Select the scanned digit and apply leading-zero blanking
    always_comb begin
        cur_digit = src_ones;
        cur_blank = 1'b0;
        case (scan_idx)
            IDX_TENS: begin
                cur_digit = src_tens;
                cur_blank = (src_hund == 4'd0) && (src_tens == 4'd0);
            end
            IDX_HUNDREDS: begin
                cur_digit = src_hund;
                cur_blank = (src_hund == 4'd0);
            end
            default: begin
                cur_digit = src_ones;
                cur_blank = 1'b0;
            end
        endcase
    end

    bcd_to_seg7 u_dec (
        .bcd   (cur_digit),
        .blank (cur_blank),
        .seg   (dec_seg)
    );

    // Registered display outputs; dark during the off half-period
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            seg      <= SEG_BLANK;
            digit_en <= 3'b000;
            flashing <= 1'b0;
        end else begin
            flashing <= (state_d != LIVE);
            if (state_d == FLASH_OFF) begin
                seg      <= SEG_BLANK;
                digit_en <= 3'b000;
            end else begin
                seg      <= dec_seg;
                digit_en <= idx_onehot(scan_idx);
            end
        end
    end

endmodule

// File: tb/tb_score_display_driver.sv
// Self-checking bench for score_display_driver.
// Reference model tracks remaining flash time and frozen score.
module tb_score_display_driver;

    localparam int S     = 4;
    localparam int B     = 8;
    localparam int F     = 2;
    localparam int TOTAL = 2 * B * F;

    logic       clk = 1'b0;
    logic       nRst;
    logic [3:0] ones;
    logic [3:0] tens;
    logic [3:0] hund;
    logic       gc;
    logic [6:0] seg;
    logic [2:0] digit_en;
    logic       flashing;

    always #5 clk = ~clk;

    score_display_driver #(
        .SCAN_DIV    (S),
        .BLINK_DIV   (B),
        .FLASH_COUNT (F)
    ) dut (
        .clk            (clk),
        .nRst           (nRst),
        .bcd_ones       (ones),
        .bcd_tens       (tens),
        .bcd_hundreds   (hund),
        .isGameComplete (gc),
        .seg            (seg),
        .digit_en       (digit_en),
        .flashing       (flashing)
    );

    int n_chk  = 0;
    int n_fail = 0;

    int m_cnt;
    int m_idx;
    int m_left;
    int m_sh[3];
    bit m_ge;
    int fl_cycles;

    function automatic logic [6:0] pat(int v);
        case (v)
            0:       return 7'h3F;
            1:       return 7'h06;
            2:       return 7'h5B;
            3:       return 7'h4F;
            4:       return 7'h66;
            5:       return 7'h6D;
            6:       return 7'h7D;
            7:       return 7'h07;
            8:       return 7'h7F;
            9:       return 7'h6F;
            default: return 7'h40;
        endcase
    endfunction

    task automatic check(string tag, logic [31:0] got,
                         logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0;
        m_idx = 0;
        m_left = 0;
        m_sh = '{0, 0, 0};
        m_ge = 1'b0;
    endtask

    task automatic set_dig(int h, int t, int o);
        hund = 4'(h);
        tens = 4'(t);
        ones = 4'(o);
    endtask

    // One clock: advance the model on the edge, then compare
    task automatic step();
        int d[3];
        int src[3];
        bit go;
        bit was_live;
        bit on;
        bit blank;
        logic [6:0] e_seg;
        logic [2:0] e_en;
        @(posedge clk);
        d = '{int'(ones), int'(tens), int'(hund)};
        go = gc && !m_ge;
        was_live = (m_left == 0);
        if (go) begin
            m_left = TOTAL;
        end else if (!was_live) begin
            m_left--;
        end else begin
            m_sh = d;
        end
        src = (m_left > 0) ? m_sh : d;
        on = (((TOTAL - m_left) / B) % 2) == 0;
        if (m_left > 0 && !on) begin
            e_seg = 7'h00;
            e_en = 3'b000;
        end else begin
            e_en = 3'(1 << m_idx);
            if (m_idx == 2) blank = (src[2] == 0);
            else if (m_idx == 1) blank = (src[2] == 0 && src[1] == 0);
            else blank = 1'b0;
            e_seg = blank ? 7'h00 : pat(src[m_idx]);
        end
        if (m_cnt == S - 1) begin
            m_cnt = 0;
            m_idx = (m_idx + 1) % 3;
        end else begin
            m_cnt++;
        end
        m_ge = gc;
        #1;
        check("seg", 32'(seg), 32'(e_seg));
        check("digit_en", 32'(digit_en), 32'(e_en));
        check("flashing", 32'(flashing), 32'(m_left > 0));
        if (flashing) fl_cycles++;
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        nRst = 1'b0;
        gc = 1'b0;
        set_dig(0, 0, 0);
        fl_cycles = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_seg", 32'(seg), 32'h0);
        check("rst_en", 32'(digit_en), 32'h0);
        check("rst_flash", 32'(flashing), 32'h0);
        @(negedge clk);
        nRst = 1'b1;

        set_dig(1, 2, 3);
        run(24);
        set_dig(0, 0, 7);
        run(12);
        set_dig(0, 5, 0);
        run(12);

        set_dig(0, 4, 2);
        run(10);
        fl_cycles = 0;
        gc = 1'b1;
        set_dig(1, 0, 5);
        step();
        gc = 1'b0;
        run(40);
        check("flash_len", 32'(fl_cycles), 32'(TOTAL));

        fl_cycles = 0;
        gc = 1'b1;
        run(100);
        gc = 1'b0;
        run(10);
        check("hold_len", 32'(fl_cycles), 32'(TOTAL));

        set_dig(3, 2, 1);
        run(5);
        fl_cycles = 0;
        gc = 1'b1;
        step();
        gc = 1'b0;
        set_dig(9, 9, 9);
        run(11);
        gc = 1'b1;
        step();
        gc = 1'b0;
        run(40);
        check("retrig_len", 32'(fl_cycles), 32'(12 + TOTAL));

        set_dig(0, 0, 12);
        run(12);
        set_dig(15, 10, 12);
        run(12);

        set_dig(2, 7, 8);
        run(3);
        gc = 1'b1;
        step();
        gc = 1'b0;
        run(10);
        #3;
        nRst = 1'b0;
        #1;
        check("arst_seg", 32'(seg), 32'h0);
        check("arst_en", 32'(digit_en), 32'h0);
        check("arst_flash", 32'(flashing), 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        nRst = 1'b1;
        model_reset();
        run(14);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0)
                set_dig(int'($urandom_range(0, 15)),
                        int'($urandom_range(0, 15)),
                        int'($urandom_range(0, 15)));
            if ($urandom_range(0, 5) == 0)
                gc = ($urandom_range(0, 9) == 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
